// File: rtl/fpcat_pkg.sv
// Shared FPCAT definitions: scene codes (also used by Pixel_Gen), screen size
// and the button hit boxes (low bounds inclusive, high bounds exclusive).
package fpcat_pkg;

  typedef enum logic [2:0] {
    SC_START = 3'd0,
    SC_MENU  = 3'd1,
    SC_PLAY1 = 3'd2,
    SC_PLAY2 = 3'd3,
    SC_PLAY3 = 3'd4,
    SC_WIN   = 3'd5,
    SC_LOSE  = 3'd6
  } scene_e;

  localparam logic [9:0] SCREEN_W = 10'd640;
  localparam logic [9:0] SCREEN_H = 10'd480;

  localparam logic [9:0] START_X0 = 10'd200;
  localparam logic [9:0] START_X1 = 10'd440;
  localparam logic [9:0] START_Y0 = 10'd270;
  localparam logic [9:0] START_Y1 = 10'd330;

  localparam logic [9:0] LVL_Y0  = 10'd200;
  localparam logic [9:0] LVL_Y1  = 10'd280;
  localparam logic [9:0] LVL1_X0 = 10'd120;
  localparam logic [9:0] LVL1_X1 = 10'd220;
  localparam logic [9:0] LVL2_X0 = 10'd270;
  localparam logic [9:0] LVL2_X1 = 10'd370;
  localparam logic [9:0] LVL3_X0 = 10'd420;
  localparam logic [9:0] LVL3_X1 = 10'd520;

  function automatic logic is_play(logic [2:0] s);
    return (s >= SC_PLAY1) && (s <= SC_PLAY3);
  endfunction

  function automatic logic is_result(logic [2:0] s);
    return (s == SC_WIN) || (s == SC_LOSE);
  endfunction

endpackage

// File: rtl/rect_hit.sv
// Combinational point-in-rectangle test: x in [X0,X1) and y in [Y0,Y1).
module rect_hit #(
  parameter logic [9:0] X0 = 10'd0,
  parameter logic [9:0] X1 = 10'd1,
  parameter logic [9:0] Y0 = 10'd0,
  parameter logic [9:0] Y1 = 10'd1
) (
  input  logic [9:0] x_i,
  input  logic [9:0] y_i,
  output logic       hit_o
);

  assign hit_o = (x_i >= X0) && (x_i < X1) && (y_i >= Y0) && (y_i < Y1);

endmodule

// File: rtl/scene_ctrl.sv
// FPCAT scene sequencer: turns clicks and win/lose pulses into a pending scene
// that is committed only on frame_start, plus level unlock mask and hover flags.
module scene_ctrl
  import fpcat_pkg::*;
#(
  parameter int RESULT_FRAMES = 180
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_start,
  input  logic [9:0] mouseX,
  input  logic [9:0] mouseY,
  input  logic       mouse_left,
  input  logic       game_win,
  input  logic       game_lose,
  output logic [2:0] scene,
  output logic       scene_change,
  output logic       mouseInStart,
  output logic [2:0] mouse_in_level,
  output logic [2:0] level_unlocked
);

  localparam int CW = $clog2(RESULT_FRAMES + 1);
  localparam logic [CW-1:0] RES_LAST = CW'(RESULT_FRAMES - 1);
  localparam logic [CW-1:0] RES_MAX  = CW'(RESULT_FRAMES);

  // scene_q is the FSM state and is exported directly as `scene`.
  logic [2:0]    scene_q, scene_d;
  scene_e        pend_scene_q, pend_scene_d;
  logic          pend_v_q, pend_v_d;
  logic [CW-1:0] res_cnt_q, res_cnt_d;
  logic          mouse_left_q;
  logic          scene_change_q, scene_change_d;
  logic          in_start_q, in_start_d;
  logic [2:0]    in_level_q, in_level_d;
  logic [2:0]    unlocked_q, unlocked_d;

  logic          click;
  logic          hit_start;
  logic [2:0]    hit_lvl;
  logic          dec_v;
  scene_e        dec_scene;

  rect_hit #(.X0(START_X0), .X1(START_X1), .Y0(START_Y0), .Y1(START_Y1)) u_hit_start (
    .x_i(mouseX), .y_i(mouseY), .hit_o(hit_start)
  );
  rect_hit #(.X0(LVL1_X0), .X1(LVL1_X1), .Y0(LVL_Y0), .Y1(LVL_Y1)) u_hit_l1 (
    .x_i(mouseX), .y_i(mouseY), .hit_o(hit_lvl[0])
  );
  rect_hit #(.X0(LVL2_X0), .X1(LVL2_X1), .Y0(LVL_Y0), .Y1(LVL_Y1)) u_hit_l2 (
    .x_i(mouseX), .y_i(mouseY), .hit_o(hit_lvl[1])
  );
  rect_hit #(.X0(LVL3_X0), .X1(LVL3_X1), .Y0(LVL_Y0), .Y1(LVL_Y1)) u_hit_l3 (
    .x_i(mouseX), .y_i(mouseY), .hit_o(hit_lvl[2])
  );

  assign click = mouse_left & ~mouse_left_q;

  // Scene decision for this cycle; whether it is accepted depends on pend_v.
  always_comb begin
    dec_v     = 1'b0;
    dec_scene = SC_START;
    case (scene_q)
      SC_START: begin
        if (click && hit_start) begin
          dec_v     = 1'b1;
          dec_scene = SC_MENU;
        end
      end
      SC_MENU: begin
        if (click) begin
          if (hit_lvl[0] && unlocked_q[0]) begin
            dec_v     = 1'b1;
            dec_scene = SC_PLAY1;
          end else if (hit_lvl[1] && unlocked_q[1]) begin
            dec_v     = 1'b1;
            dec_scene = SC_PLAY2;
          end else if (hit_lvl[2] && unlocked_q[2]) begin
            dec_v     = 1'b1;
            dec_scene = SC_PLAY3;
          end
        end
      end
      SC_PLAY1, SC_PLAY2, SC_PLAY3: begin
        if (game_lose) begin
          dec_v     = 1'b1;
          dec_scene = SC_LOSE;
        end else if (game_win) begin
          dec_v     = 1'b1;
          dec_scene = SC_WIN;
        end
      end
      SC_WIN, SC_LOSE: begin
        if (click || (frame_start && (res_cnt_q == RES_LAST))) begin
          dec_v     = 1'b1;
          dec_scene = SC_MENU;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    scene_d        = scene_q;
    pend_v_d       = pend_v_q;
    pend_scene_d   = pend_scene_q;
    res_cnt_d      = res_cnt_q;
    scene_change_d = 1'b0;
    unlocked_d     = unlocked_q;

    if (game_win && (scene_q == SC_PLAY1)) unlocked_d[1] = 1'b1;
    if (game_win && (scene_q == SC_PLAY2)) unlocked_d[2] = 1'b1;

    // The result timeout counter saturates and freezes once a decision is pending.
    if (is_result(scene_q) && frame_start && !pend_v_q && (res_cnt_q != RES_MAX))
      res_cnt_d = res_cnt_q + 1'b1;

    if (scene_q > SC_LOSE) begin
      scene_d   = SC_START;
      pend_v_d  = 1'b0;
      res_cnt_d = '0;
    end else if (frame_start && pend_v_q) begin
      scene_d        = pend_scene_q;
      pend_v_d       = 1'b0;
      res_cnt_d      = '0;
      scene_change_d = 1'b1;
    end else if (dec_v && !pend_v_q) begin
      pend_v_d     = 1'b1;
      pend_scene_d = dec_scene;
    end

    in_start_d = (scene_q == SC_START) && hit_start;
    in_level_d = (scene_q == SC_MENU) ? hit_lvl : 3'b000;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scene_q        <= SC_START;
      pend_v_q       <= 1'b0;
      pend_scene_q   <= SC_START;
      res_cnt_q      <= '0;
      mouse_left_q   <= 1'b0;
      scene_change_q <= 1'b0;
      in_start_q     <= 1'b0;
      in_level_q     <= 3'b000;
      unlocked_q     <= 3'b001;
    end else begin
      scene_q        <= scene_d;
      pend_v_q       <= pend_v_d;
      pend_scene_q   <= pend_scene_d;
      res_cnt_q      <= res_cnt_d;
      mouse_left_q   <= mouse_left;
      scene_change_q <= scene_change_d;
      in_start_q     <= in_start_d;
      in_level_q     <= in_level_d;
      unlocked_q     <= unlocked_d;
    end
  end

  assign scene          = scene_q;
  assign scene_change   = scene_change_q;
  assign mouseInStart   = in_start_q;
  assign mouse_in_level = in_level_q;
  assign level_unlocked = unlocked_q;

endmodule

// File: tb/tb_scene_ctrl.sv
// Bench for scene_ctrl: directed scenarios followed by random clicks/events,
// all checked against a scene-level reference model and a commit scoreboard.
module tb_scene_ctrl;

  localparam int RF = 3;

  logic       clk;
  logic       rst_n;
  logic       frame_start;
  logic [9:0] mouseX;
  logic [9:0] mouseY;
  logic       mouse_left;
  logic       game_win;
  logic       game_lose;
  logic [2:0] scene;
  logic       scene_change;
  logic       mouseInStart;
  logic [2:0] mouse_in_level;
  logic [2:0] level_unlocked;

  scene_ctrl #(.RESULT_FRAMES(RF)) dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start),
    .mouseX(mouseX), .mouseY(mouseY), .mouse_left(mouse_left),
    .game_win(game_win), .game_lose(game_lose),
    .scene(scene), .scene_change(scene_change),
    .mouseInStart(mouseInStart), .mouse_in_level(mouse_in_level),
    .level_unlocked(level_unlocked)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  bit mon_en = 1'b0;
  logic [2:0] exp_q[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Box table: 0 = START button, 1..3 = level buttons
  int bx0[4] = '{200, 120, 270, 420};
  int bx1[4] = '{440, 220, 370, 520};
  int by0[4] = '{270, 200, 200, 200};
  int by1[4] = '{330, 280, 280, 280};

  function automatic bit in_box(input int b, input int x, input int y);
    return (x >= bx0[b]) && (x < bx1[b]) && (y >= by0[b]) && (y < by1[b]);
  endfunction

  // Reference model: scene numbers as ints, decided from the screen rules
  int       m_scene = 0;
  bit       m_pend = 1'b0;
  int       m_pend_scene = 0;
  int       m_cnt = 0;
  bit [2:0] m_unl = 3'b001;
  bit       m_left_q = 1'b0;
  bit       m_change = 1'b0;
  bit       m_hs = 1'b0;
  bit [2:0] m_hl = 3'b000;

  always @(posedge clk) begin
    int x, y, nd;
    bit clk_c;
    bit [2:0] hl;
    x = int'(mouseX);
    y = int'(mouseY);
    if (!rst_n) begin
      m_scene <= 0; m_pend <= 1'b0; m_pend_scene <= 0; m_cnt <= 0;
      m_unl <= 3'b001; m_left_q <= 1'b0; m_change <= 1'b0;
      m_hs <= 1'b0; m_hl <= 3'b000;
    end else begin
      clk_c = mouse_left && !m_left_q;
      nd = -1;
      if (m_scene == 0) begin
        if (clk_c && in_box(0, x, y)) nd = 1;
      end else if (m_scene == 1) begin
        if (clk_c)
          for (int k = 0; k < 3; k++)
            if (nd < 0 && in_box(k + 1, x, y) && m_unl[k]) nd = 2 + k;
      end else if (m_scene <= 4) begin
        if (game_lose) nd = 6;
        else if (game_win) nd = 5;
      end else begin
        if (clk_c || (frame_start && m_cnt == RF - 1)) nd = 1;
      end
      if (game_win && (m_scene == 2 || m_scene == 3))
        m_unl <= m_unl | 3'(1 << (m_scene - 1));
      for (int k = 0; k < 3; k++) hl[k] = (m_scene == 1) && in_box(k + 1, x, y);
      m_hl <= hl;
      m_hs <= (m_scene == 0) && in_box(0, x, y);
      m_left_q <= mouse_left;
      if (frame_start && m_pend) begin
        m_scene <= m_pend_scene;
        m_pend <= 1'b0;
        m_cnt <= 0;
        m_change <= 1'b1;
        exp_q.push_back(3'(m_pend_scene));
      end else begin
        m_change <= 1'b0;
        if (nd >= 0 && !m_pend) begin
          m_pend <= 1'b1;
          m_pend_scene <= nd;
        end
        if (m_scene >= 5 && frame_start && !m_pend && m_cnt < RF) m_cnt <= m_cnt + 1;
      end
    end
  end

  // Monitor: per-cycle output compare plus commit scoreboard
  always @(negedge clk) begin
    if (mon_en) begin
      chk("scene", int'(scene), m_scene);
      chk("scene_change", int'(scene_change), int'(m_change));
      chk("level_unlocked", int'(level_unlocked), int'(m_unl));
      chk("mouseInStart", int'(mouseInStart), int'(m_hs));
      chk("mouse_in_level", int'(mouse_in_level), int'(m_hl));
      if (scene_change) begin
        if (exp_q.size() == 0) begin
          chk("sb_unexpected_commit", int'(scene), -1);
        end else begin
          logic [2:0] e;
          e = exp_q.pop_front();
          chk("sb_commit_scene", int'(scene), int'(e));
        end
      end
    end
  end

  // Driver tasks
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic click_at(input int x, input int y);
    mouseX = 10'(x);
    mouseY = 10'(y);
    mouse_left = 1'b1;
    tick();
    mouse_left = 1'b0;
    tick();
  endtask

  task automatic do_reset(input int cycles);
    rst_n = 1'b0;
    repeat (cycles) tick();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; frame_start = 1'b0; mouseX = '0; mouseY = '0;
    mouse_left = 1'b0; game_win = 1'b0; game_lose = 1'b0;
    repeat (3) tick();
    chk("rst_scene", int'(scene), 0);
    chk("rst_unlocked", int'(level_unlocked), 1);
    chk("rst_scene_change", int'(scene_change), 0);
    chk("rst_hover", int'({mouseInStart, mouse_in_level}), 0);
    rst_n = 1'b1;
    mon_en = 1'b1;

    // START -> MENU on a frame 50 cycles after the click
    click_at(300, 300);
    chk("hover_start_in", int'(mouseInStart), 1);
    repeat (50) tick();
    chk("start_wait_scene", int'(scene), 0);
    frame();
    chk("menu_commit", int'(scene), 1);
    chk("menu_change_pulse", int'(scene_change), 1);
    tick();
    chk("menu_change_once", int'(scene_change), 0);

    // Locked level 2 ignored, level 1 accepted
    click_at(300, 240);
    chk("hover_lvl2", int'(mouse_in_level), 2);
    frame();
    chk("locked_l2_ignored", int'(scene), 1);
    click_at(150, 240);
    frame();
    chk("play1_commit", int'(scene), 2);

    // Win and lose together: LOSE, and level 2 unlocked
    game_win = 1'b1; game_lose = 1'b1;
    tick();
    game_win = 1'b0; game_lose = 1'b0;
    chk("unlock_after_win", int'(level_unlocked), 3);
    frame();
    chk("lose_wins_tie", int'(scene), 6);

    click_at(10, 10);
    frame();
    chk("lose_click_menu", int'(scene), 1);
    click_at(300, 240);
    frame();
    chk("play2_commit", int'(scene), 3);
    game_win = 1'b1;
    tick();
    game_win = 1'b0;
    chk("unlock_l3", int'(level_unlocked), 7);
    frame();
    chk("win_commit", int'(scene), 5);

    // Result timeout: back to MENU on the 4th frame after entry
    for (int f = 1; f <= 4; f++) begin
      repeat (3) tick();
      frame();
      chk($sformatf("win_timeout_f%0d", f), int'(scene), (f == 4) ? 1 : 5);
    end

    // Second click while pending is dropped
    click_at(150, 240);
    click_at(300, 240);
    frame();
    chk("second_click_dropped", int'(scene), 2);

    // Reset with a decision pending loses it
    game_lose = 1'b1;
    tick();
    game_lose = 1'b0;
    do_reset(3);
    chk("midrst_scene", int'(scene), 0);
    chk("midrst_unlocked", int'(level_unlocked), 1);
    frame();
    chk("midrst_pend_lost", int'(scene), 0);

    // Button held through reset is seen as a click
    mouseX = 10'd300; mouseY = 10'd300; mouse_left = 1'b1;
    do_reset(3);
    tick();
    mouse_left = 1'b0;
    tick();
    frame();
    chk("held_button_click", int'(scene), 1);

    // Illegal scene code returns to START after one edge
    do_reset(2);
    mouseX = '0; mouseY = '0;
    tick();
    #2;
    force dut.scene_q = 3'd7;
    #1;
    release dut.scene_q;
    tick();
    chk("illegal_to_start", int'(scene), 0);

    // Click and frame_start in the same cycle commit one frame later
    mouseX = 10'd300; mouseY = 10'd300; mouse_left = 1'b1; frame_start = 1'b1;
    tick();
    mouse_left = 1'b0; frame_start = 1'b0;
    chk("same_cycle_no_commit", int'(scene), 0);
    repeat (4) tick();
    frame();
    chk("same_cycle_next_frame", int'(scene), 1);

    // Random phase
    do_reset(2);
    begin
      int period;
      int since;
      period = 8;
      since = 0;
      for (int c = 0; c < 4000; c++) begin
        if (c == 2000) do_reset(2);
        since++;
        frame_start = (since >= period);
        if (frame_start) begin
          since = 0;
          period = $urandom_range(4, 14);
        end
        if ($urandom_range(0, 5) == 0) begin
          int b;
          b = $urandom_range(0, 4);
          if (b == 4) begin
            mouseX = 10'($urandom_range(0, 639));
            mouseY = 10'($urandom_range(0, 479));
          end else begin
            mouseX = 10'($urandom_range(bx0[b] - 3, bx1[b] + 2));
            mouseY = 10'($urandom_range(by0[b] - 3, by1[b] + 2));
          end
        end
        if ($urandom_range(0, 3) == 0) mouse_left = ~mouse_left;
        game_win  = ($urandom_range(0, 11) == 0);
        game_lose = ($urandom_range(0, 13) == 0);
        tick();
      end
      frame_start = 1'b0; mouse_left = 1'b0; game_win = 1'b0; game_lose = 1'b0;
      repeat (3) tick();
    end

    chk("sb_queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
